// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle between decode and the register file.
//   master : drives write port, reserve port and read indices; receives
//            read data, busy flags and ready.
//   slave  : the register file side.
//   XLEN   : data width, AW : register index width.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            wr_en;
    logic [AW-1:0]   wr_reg;
    logic [XLEN-1:0] wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_reg;
    logic [AW-1:0]   rd_reg_1;
    logic [AW-1:0]   rd_reg_2;
    logic [XLEN-1:0] rd_data_1;
    logic [XLEN-1:0] rd_data_2;
    logic            busy_1;
    logic            busy_2;
    logic            ready;

    modport master (
        output wr_en, wr_reg, wr_data, rsv_en, rsv_reg, rd_reg_1, rd_reg_2,
        input  rd_data_1, rd_data_2, busy_1, busy_2, ready
    );

    modport slave (
        input  wr_en, wr_reg, wr_data, rsv_en, rsv_reg, rd_reg_1, rd_reg_2,
        output rd_data_1, rd_data_2, busy_1, busy_2, ready
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with busy scoreboard.
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset; starts the clear sweep
//   bus  : regfile_sb_if.slave
//          wr_en/wr_reg/wr_data   write port (clears busy)
//          rsv_en/rsv_reg         reserve port (sets busy)
//          rd_reg_n -> rd_data_n, busy_n   combinational read ports
//          ready                  clear sweep finished, file usable
// Register 0 is hard zero. After reset the array is swept to zero one entry
// per cycle (x1..x(REG_COUNT-1)); outputs read as zero until that finishes.
module regfile_sb #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int BYPASS    = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(REG_COUNT);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       clr_idx_q, clr_idx_d;
    logic [XLEN-1:0]     mem [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;

    logic wr_fire, rsv_fire;

    // sweep state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(REG_COUNT - 1))
                    state_d = READY;
            end
            default: ;
        endcase
    end

    // writes and reservations are dropped entirely while sweeping
    assign wr_fire  = (state_q == READY) && bus.wr_en  && (bus.wr_reg  != '0);
    assign rsv_fire = (state_q == READY) && bus.rsv_en && (bus.rsv_reg != '0);

    // array has no reset of its own; the sweep zeroes it. A write presented
    // on a reset edge is discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR)
                mem[clr_idx_q] <= '0;
            else if (wr_fire)
                mem[bus.wr_reg] <= bus.wr_data;
        end
    end

    // reserve is applied after write so a same-register collision stays busy:
    // the reservation stands for a younger producer still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            if (wr_fire)
                busy_q[bus.wr_reg] <= 1'b0;
            if (rsv_fire)
                busy_q[bus.rsv_reg] <= 1'b1;
        end
    end

    // read ports
    logic [1:0][AW-1:0]   rd_idx;
    logic [1:0][XLEN-1:0] rd_val;
    logic [1:0]           rd_bsy;

    always_comb begin
        rd_idx[0] = bus.rd_reg_1;
        rd_idx[1] = bus.rd_reg_2;
        rd_val    = '0;
        rd_bsy    = '0;
        for (int p = 0; p < 2; p++) begin
            if (state_q == READY && rd_idx[p] != '0) begin
                if (BYPASS != 0 && bus.wr_en && bus.wr_reg == rd_idx[p]) begin
                    // forwarded value is the completed writeback: not busy
                    rd_val[p] = bus.wr_data;
                end else begin
                    rd_val[p] = mem[rd_idx[p]];
                    rd_bsy[p] = busy_q[rd_idx[p]];
                end
            end
        end
    end

    assign bus.rd_data_1 = rd_val[0];
    assign bus.rd_data_2 = rd_val[1];
    assign bus.busy_1    = rd_bsy[0];
    assign bus.busy_2    = rd_bsy[1];
    assign bus.ready     = (state_q == READY);
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: three register files (32x32 bypass, 32x32 no bypass,
// 16x64 bypass) share one stimulus stream; every cycle all outputs are
// compared against a behavioural model of the file.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en = 0, rsv_en = 0;
    logic [4:0]  wr_reg = 0, rsv_reg = 0, rd_reg_1 = 0, rd_reg_2 = 0;
    logic [63:0] wr_data = 0;

    regfile_sb_if #(.XLEN(32), .AW(5)) ifa ();
    regfile_sb_if #(.XLEN(32), .AW(5)) ifb ();
    regfile_sb_if #(.XLEN(64), .AW(4)) ifc ();

    assign ifa.wr_en = wr_en;          assign ifb.wr_en = wr_en;          assign ifc.wr_en = wr_en;
    assign ifa.wr_reg = wr_reg;        assign ifb.wr_reg = wr_reg;        assign ifc.wr_reg = wr_reg[3:0];
    assign ifa.wr_data = wr_data[31:0]; assign ifb.wr_data = wr_data[31:0]; assign ifc.wr_data = wr_data;
    assign ifa.rsv_en = rsv_en;        assign ifb.rsv_en = rsv_en;        assign ifc.rsv_en = rsv_en;
    assign ifa.rsv_reg = rsv_reg;      assign ifb.rsv_reg = rsv_reg;      assign ifc.rsv_reg = rsv_reg[3:0];
    assign ifa.rd_reg_1 = rd_reg_1;    assign ifb.rd_reg_1 = rd_reg_1;    assign ifc.rd_reg_1 = rd_reg_1[3:0];
    assign ifa.rd_reg_2 = rd_reg_2;    assign ifb.rd_reg_2 = rd_reg_2;    assign ifc.rd_reg_2 = rd_reg_2[3:0];

    regfile_sb #(.XLEN(32), .REG_COUNT(32), .BYPASS(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    regfile_sb #(.XLEN(32), .REG_COUNT(32), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    regfile_sb #(.XLEN(64), .REG_COUNT(16), .BYPASS(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    logic [63:0] o_d1 [3], o_d2 [3];
    logic        o_b1 [3], o_b2 [3], o_rdy [3];
    assign o_d1[0] = {32'b0, ifa.rd_data_1}; assign o_d2[0] = {32'b0, ifa.rd_data_2};
    assign o_d1[1] = {32'b0, ifb.rd_data_1}; assign o_d2[1] = {32'b0, ifb.rd_data_2};
    assign o_d1[2] = ifc.rd_data_1;          assign o_d2[2] = ifc.rd_data_2;
    assign o_b1[0] = ifa.busy_1; assign o_b2[0] = ifa.busy_2; assign o_rdy[0] = ifa.ready;
    assign o_b1[1] = ifb.busy_1; assign o_b2[1] = ifb.busy_2; assign o_rdy[1] = ifb.ready;
    assign o_b1[2] = ifc.busy_1; assign o_b2[2] = ifc.busy_2; assign o_rdy[2] = ifc.ready;

    // ---------------- reference model ----------------
    int          rc  [3] = '{32, 32, 16};
    bit          byp [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] msk [3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, '1};
    logic [63:0] m_mem  [3][32];
    bit          m_busy [3][32];
    int          m_since [3];     // rising edges with rst=0 since last reset

    int vectors = 0, miscompares = 0;

    function automatic bit m_ready(int k);
        return m_since[k] >= rc[k] - 1;
    endfunction

    // {busy, data} a read of register r should return right now
    function automatic logic [64:0] exp_rd(int k, logic [4:0] r);
        int ri = int'(r) % rc[k];
        int wi = int'(wr_reg) % rc[k];
        if (!m_ready(k) || ri == 0) return '0;
        if (byp[k] && wr_en && wi == ri) return {1'b0, wr_data & msk[k]};
        return {m_busy[k][ri], m_mem[k][ri]};
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int wi = int'(wr_reg) % rc[k];
            int si = int'(rsv_reg) % rc[k];
            if (rst) begin
                m_since[k] = 0;
                for (int r = 0; r < 32; r++) m_busy[k][r] = 0;
            end else if (!m_ready(k)) begin
                m_since[k]++;
                // sweep done: whole file reads zero
                if (m_ready(k))
                    for (int r = 0; r < 32; r++) m_mem[k][r] = '0;
            end else begin
                if (wr_en && wi != 0) begin
                    m_mem[k][wi]  = wr_data & msk[k];
                    m_busy[k][wi] = 0;
                end
                if (rsv_en && si != 0) m_busy[k][si] = 1;
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [64:0] e1 = exp_rd(k, rd_reg_1);
            logic [64:0] e2 = exp_rd(k, rd_reg_2);
            chk($sformatf("ready[%0d]", k), {63'b0, o_rdy[k]}, {63'b0, m_ready(k)});
            chk($sformatf("rd1[%0d] x%0d", k, rd_reg_1), o_d1[k], e1[63:0]);
            chk($sformatf("busy1[%0d] x%0d", k, rd_reg_1), {63'b0, o_b1[k]}, {63'b0, e1[64]});
            chk($sformatf("rd2[%0d] x%0d", k, rd_reg_2), o_d2[k], e2[63:0]);
            chk($sformatf("busy2[%0d] x%0d", k, rd_reg_2), {63'b0, o_b2[k]}, {63'b0, e2[64]});
        end
    endtask

    // inputs already set by caller; check combinational outputs, then clock
    task automatic step();
        #2;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rsv_en = 0; rst = 0;
    endtask

    initial begin
        int na, nc;
        for (int k = 0; k < 3; k++) begin
            m_since[k] = 0;
            for (int r = 0; r < 32; r++) begin m_mem[k][r] = '0; m_busy[k][r] = 0; end
        end
        // first edge brings the DUTs out of the unknown power-up state
        rst = 1;
        @(posedge clk); model_edge(); #1;

        // ---- reset sweep ----
        step(); step(); step();
        idle();
        na = -1; nc = -1;
        for (int n = 0; n < 40; n++) begin
            if (ifa.ready === 1'b1 && na < 0) na = n;
            if (ifc.ready === 1'b1 && nc < 0) nc = n;
            step();
        end
        chk("sweep_edges_32", 64'(na), 64'd31);
        chk("sweep_edges_16", 64'(nc), 64'd15);
        for (int i = 1; i < 32; i++) begin
            rd_reg_1 = 5'(i); rd_reg_2 = 5'(32 - i); step();
        end

        // ---- write/read and x0 ----
        wr_en = 1; wr_reg = 5; wr_data = 64'hDEADBEEF; step();
        idle(); rd_reg_1 = 5; rd_reg_2 = 5; step();
        wr_en = 1; wr_reg = 0; wr_data = 64'h1234; step();
        idle(); rd_reg_1 = 0; rd_reg_2 = 0; step();
        chk("x0_direct", {32'b0, ifa.rd_data_1}, 64'h0);

        // ---- bypass ----
        wr_en = 1; wr_reg = 7; wr_data = 64'h11; step();
        wr_en = 1; wr_reg = 7; wr_data = 64'h22; rd_reg_1 = 7; #2;
        chk("byp1_same_cycle", {32'b0, ifa.rd_data_1}, 64'h22);
        chk("byp0_same_cycle", {32'b0, ifb.rd_data_1}, 64'h11);
        step();
        idle(); step();

        // ---- scoreboard ----
        rsv_en = 1; rsv_reg = 9; rd_reg_1 = 9; step();
        idle(); step();
        wr_en = 1; wr_reg = 9; wr_data = 64'h55; step();
        idle(); step();
        wr_en = 1; wr_reg = 9; wr_data = 64'h66; rsv_en = 1; rsv_reg = 9; step();
        idle(); step();
        chk("wr_rsv_collide_busy", {63'b0, ifa.busy_1}, 64'h1);

        // ---- reset mid-operation ----
        wr_en = 1; wr_reg = 3; wr_data = 64'hAA; rsv_en = 1; rsv_reg = 4; step();
        idle(); rd_reg_1 = 3; rd_reg_2 = 4; step();
        rst = 1; wr_en = 1; wr_reg = 3; wr_data = 64'hBB; step();
        idle();
        for (int n = 0; n < 10; n++) begin
            wr_en = 1; wr_reg = 3; wr_data = 64'(n); rsv_en = 1; rsv_reg = 4; step();
        end
        rst = 1; step();
        idle();
        for (int n = 0; n < 35; n++) begin
            wr_en = n[0]; wr_reg = 4; rsv_en = 1; rsv_reg = 3; wr_data = 64'hCC;
            rd_reg_1 = 3; rd_reg_2 = 4; step();
        end
        idle(); rd_reg_1 = 3; rd_reg_2 = 4; step();

        // ---- 64-bit width ----
        wr_en = 1; wr_reg = 15; wr_data = 64'hFFFF_0000_FFFF_0001; step();
        idle(); rd_reg_1 = 15; rd_reg_2 = 0; step();
        chk("x15_64bit", ifc.rd_data_1, 64'hFFFF_0000_FFFF_0001);

        // ---- random traffic with occasional reset ----
        for (int n = 0; n < 1500; n++) begin
            rst      = ($urandom_range(0, 79) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_reg   = 5'($urandom);
            wr_data  = {32'($urandom), 32'($urandom)};
            rsv_en   = $urandom_range(0, 2) == 0;
            rsv_reg  = 5'($urandom);
            rd_reg_1 = ($urandom_range(0, 3) == 0) ? wr_reg : 5'($urandom);
            rd_reg_2 = ($urandom_range(0, 3) == 0) ? rsv_reg : 5'($urandom);
            step();
        end
        idle(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the rv32i core, generalising the fixed 32 x 32-bit file. It adds configurable data width and register count, optional same-cycle write-to-read bypass, a per-register busy scoreboard for in-flight writebacks from multicycle units, and a post-reset clear sweep. It sits in decode, feeding operand reads and hazard detection.

## Interface
- XLEN, 32, data width in bits
- REG_COUNT, 32, number of architectural registers; power of 2, minimum 2
- BYPASS, 1, 1 = write data forwarded to matching read ports in the same cycle; 0 = reads see stored value only
- (derived) AW = $clog2(REG_COUNT), register index width

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write enable
- wr_reg  input  AW  write register index
- wr_data  input  XLEN  write data
- rsv_en  input  1  reserve request; marks rsv_reg busy (pending writeback)
- rsv_reg  input  AW  register index to reserve
- rd_reg_1  input  AW  read port 1 index
- rd_reg_2  input  AW  read port 2 index
- rd_data_1  output  XLEN  read port 1 data (combinational)
- rd_data_2  output  XLEN  read port 2 data (combinational)
- busy_1  output  1  rd_reg_1 has a pending reservation (combinational)
- busy_2  output  1  rd_reg_2 has a pending reservation (combinational)
- ready  output  1  1 = clear sweep complete, file usable

## Operation
- Storage: REG_COUNT x XLEN array plus REG_COUNT busy bits. Register 0 is hard zero: never written, never busy, reads return 0.
- FSM states: CLEAR and READY.
  - rst=1 at an edge: state <= CLEAR, clr_idx <= 1, all busy bits <= 0. Array contents are not reset directly.
  - CLEAR with rst=0: at each edge, array[clr_idx] <= 0 and clr_idx <= clr_idx+1. On the edge where clr_idx == REG_COUNT-1, state <= READY.
  - READY: remains until rst.
- During CLEAR:
  - ready=0.
  - rd_data_n=0 and busy_n=0 on both ports.
  - wr_en and rsv_en are ignored; no array or busy update.
- Write (READY): wr_en=1 and wr_reg!=0 causes array[wr_reg] <= wr_data and busy[wr_reg] <= 0 at the edge.
- Reserve (READY): rsv_en=1 and rsv_reg!=0 causes busy[rsv_reg] <= 1 at the edge.
- Simultaneous write and reserve of the same register: data is written and busy ends up 1. The reservation wins because it represents a newer in-flight producer.
- Simultaneous write and reserve of different registers: both take effect.
- Read port n (READY):
  - rd_reg_n==0 gives data 0, busy 0.
  - If BYPASS=1 and wr_en=1 and wr_reg==rd_reg_n!=0: rd_data_n=wr_data and busy_n=0.
  - Otherwise rd_data_n=array[rd_reg_n] and busy_n=busy[rd_reg_n].
- Reserving an already-busy register leaves it busy; no counting.
- A write to a non-busy register is legal.

## Timing
- Reset values:
  - ready=0, state CLEAR, all busy bits 0.
  - rd_data_1/2=0 and busy_1/2=0 while in CLEAR.
- Sweep latency: ready rises after exactly REG_COUNT-1 rising edges with rst=0, counted from the first edge after rst deasserts. For the default configuration this is 31 cycles.
- Reset asserted mid-sweep restarts the sweep at clr_idx=1.
- Reset asserted in READY drops ready on that edge, clears busy bits and restarts the sweep. Any write presented on that edge is discarded.
- Reads are zero-latency combinational from array, busy and write-port inputs.
- Write and reserve take effect at the rising edge. They are visible through stored state from the next cycle on.
- With BYPASS=0, a same-cycle read of the register being written returns the old value and the old busy bit.

## Test plan
- **Reset sweep.** Hold rst 3 cycles, release, poll ready. ready=0 for exactly 31 edges, then 1. Afterwards every register x1..x31 reads 0 and busy_1/2=0.
- **Write/read and x0.** Write 0xDEADBEEF to x5, then read x5 on both ports: returns 0xDEADBEEF. Write 0x1234 to x0, then read x0: returns 0 and busy=0.
- **Bypass.**
  - BYPASS=1: with x7=0x11, present wr_en, wr_reg=7, wr_data=0x22 and rd_reg_1=7 in the same cycle. rd_data_1=0x22 in that cycle.
  - BYPASS=0, same stimulus: rd_data_1=0x11 in that cycle and 0x22 the next cycle.
- **Scoreboard.**
  - Reserve x9: busy_1=1 for rd_reg_1=9 from the next cycle.
  - Write x9=0x55: busy clears from the next cycle; with BYPASS=1, busy_1=0 already in the write cycle.
  - Write and reserve x9 in the same cycle: busy stays 1 and data=new value.
- **Reset mid-operation.** In READY with x3=0xAA and x4 busy, assert rst for 1 cycle at sweep step 10, then again. ready remains 0 until 31 edges after the last release. x3 then reads 0, busy_2=0 for x4, and writes or reserves presented during CLEAR have no effect.
- **Parameter sweep.** Use XLEN=64, REG_COUNT=16. ready rises after 15 edges, a 64-bit write 0xFFFF_0000_FFFF_0001 to x15 reads back intact, and x0 remains 0.
